// File: rtl/result_encoder.sv
// result_encoder: return path of the UART command processor.
// Captures one finished ALU result, formats it as an ASCII response frame
// ("R<op><hex hi><hex lo>\r\n" or "E<op>\r\n") and hands the frame to the
// UART transmitter one byte at a time over a start/busy handshake.
module result_encoder #(
    parameter int RES_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RES_W-1:0] result,
    input  logic [1:0]       opcode,
    input  logic             res_err,
    input  logic             res_valid,
    output logic             res_ack,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    output logic             frame_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Converts one nibble to its uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] code;
        if (nib < 4'd10) begin
            code = 8'h30 + {4'h0, nib};
        end else begin
            code = 8'h37 + {4'h0, nib};
        end
        return code;
    endfunction

    // Index of the final byte: error frames are 4 bytes, normal frames 6.
    function automatic logic [2:0] last_index(input logic err);
        logic [2:0] last;
        if (err) begin
            last = 3'd3;
        end else begin
            last = 3'd5;
        end
        return last;
    endfunction

    // Selects frame byte number idx purely from the captured result fields.
    function automatic logic [7:0] frame_byte(
        input logic [2:0] idx,
        input logic       err,
        input logic [1:0] op,
        input logic [7:0] res
    );
        logic [7:0] b;
        logic [7:0] op_digit;
        op_digit = 8'h30 + {6'h00, op};
        if (err) begin
            case (idx)
                3'd0:    b = 8'h45;
                3'd1:    b = op_digit;
                3'd2:    b = 8'h0D;
                3'd3:    b = 8'h0A;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0:    b = 8'h52;
                3'd1:    b = op_digit;
                3'd2:    b = hex_ascii(res[7:4]);
                3'd3:    b = hex_ascii(res[3:0]);
                3'd4:    b = 8'h0D;
                3'd5:    b = 8'h0A;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] res_q, res_d;
    logic [1:0] op_q, op_d;
    logic       err_q, err_d;
    logic       res_ack_q, res_ack_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       frame_busy_q, frame_busy_d;

    // Next-state logic: capture in IDLE, then START/HOLD/DRAIN per frame byte.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        res_d        = res_q;
        op_d         = op_q;
        err_d        = err_q;
        res_ack_d    = 1'b0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (res_valid) begin
                    res_d     = 8'(result);
                    op_d      = opcode;
                    err_d     = res_err;
                    idx_d     = 3'd0;
                    res_ack_d = 1'b1;
                    state_d   = ST_START;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                // Never request a byte while the transmitter is still busy.
                if (!tx_busy) begin
                    tx_data_d  = frame_byte(idx_q, err_q, op_q, res_q);
                    tx_start_d = 1'b1;
                    state_d    = ST_HOLD;
                end else begin
                    state_d    = ST_START;
                end
            end
            ST_HOLD: begin
                // Transmitter raises busy one cycle after seeing tx_start.
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    if (idx_q == last_index(err_q)) begin
                        idx_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_START;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                idx_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
        frame_busy_d = (state_d != ST_IDLE);
    end

    // State, captured fields and registered outputs; reset abandons any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            res_q        <= 8'h00;
            op_q         <= 2'd0;
            err_q        <= 1'b0;
            res_ack_q    <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            res_q        <= res_d;
            op_q         <= op_d;
            err_q        <= err_d;
            res_ack_q    <= res_ack_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            frame_busy_q <= frame_busy_d;
        end
    end

    assign res_ack    = res_ack_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign frame_busy = frame_busy_q;

endmodule

// File: doc/result_encoder.md
# result_encoder

Return-path block of the UART command processor. Accepts a finished ALU result over a valid/ack handshake, formats it as an ASCII response frame, and feeds the frame byte-by-byte to the UART transmitter through a start/busy handshake. It is the outbound counterpart of the command decoder: the decoder turns received bytes into commands for the ALU, and this block turns ALU results into transmitted bytes.

## Interface
- RES_W, 6, ALU result width; legal range 1..8; zero-extended to 8 bits for encoding
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- result  in  RES_W  ALU result, valid while res_valid=1
- opcode  in  2  opcode of the completed command, echoed in the frame
- res_err  in  1  1 = error result; selects the error frame
- res_valid  in  1  ALU has a result; held high until res_ack is seen
- res_ack  out  1  one-cycle pulse; result captured
- tx_data  out  8  byte to transmit; stable from tx_start until the next byte is loaded
- tx_start  out  1  one-cycle pulse; requests transmission of tx_data
- tx_busy  in  1  UART transmitter busy
- frame_busy  out  1  frame in progress; encoder not accepting results

## Operation
- Frame formats:
  - Normal, 6 bytes: 'R'(0x52), opcode digit (0x30+opcode), hex high nibble, hex low nibble, CR(0x0D), LF(0x0A).
  - Error (res_err=1), 4 bytes: 'E'(0x45), opcode digit, CR, LF.
- Hex digits are uppercase: nibble 0-9 maps to 0x30+n, and nibble A-F maps to 0x37+n. The nibbles come from the 8-bit zero-extended result.
- Capture: in IDLE, if res_valid=1, the block registers result, opcode and res_err, pulses res_ack for exactly one cycle and goes to START.
- res_valid is ignored in every state except IDLE. The ALU deasserts res_valid on the cycle after it sees res_ack.
- A byte index counts from 0 to the frame length minus 1. The index selects the byte from the captured registers only; live inputs are never read after capture.
- State machine:
  - IDLE -> START on res_valid.
  - START: wait while tx_busy=1. When tx_busy=0, load tx_data with the byte at the current index, pulse tx_start, and go to HOLD.
  - HOLD: one cycle unconditionally, then go to DRAIN. This covers the transmitter's one-cycle busy latency.
  - DRAIN: wait while tx_busy=1. When tx_busy=0, go to IDLE if the index is the last one; otherwise increment the index and go to START.
- frame_busy=1 in START, HOLD and DRAIN, and 0 in IDLE.
- Reset values: res_ack=0, tx_start=0, tx_data=0x00, frame_busy=0, state=IDLE, index=0.

## Timing
- Reset acts asynchronously and forces all outputs to their reset values immediately. If reset is asserted mid-frame, the frame is abandoned with no further tx_start. The next accepted result starts a fresh frame at byte 0.
- res_valid sampled high at edge k: res_ack and frame_busy are high in cycle k+1; the first tx_start is high in cycle k+2.
- Transmitter contract: tx_busy goes high on the cycle after it samples tx_start=1, and stays high until the byte has finished.
- Per byte, with an idle transmitter: tx_start, then HOLD, then DRAIN for the transmitter's busy time, then one START cycle before the next tx_start.
- Exactly one tx_start per frame byte. tx_start never occurs while tx_busy=1.
- The edge on which DRAIN sees tx_busy=0 on the last byte moves the block to IDLE. A res_valid already high in that IDLE cycle is accepted at the next edge.
- If res_valid and reset release coincide, the block captures on the first edge after reset deasserts.

## Test plan
- Reset: assert reset with clk running and random inputs -> res_ack=0, tx_start=0, tx_data=0x00, frame_busy=0 without waiting for a clock edge.
- Normal frame: result=6'h2A, opcode=1, res_err=0, model transmitter busy 10 cycles per byte -> one res_ack; tx_data sequence 0x52 0x31 0x32 0x41 0x0D 0x0A; six tx_start pulses; frame_busy returns to 0.
- Error frame: res_err=1, opcode=3, result=6'h3F -> tx_data sequence 0x45 0x33 0x0D 0x0A; four tx_start pulses.
- Busy stall: tx_busy forced high for 20 cycles while in START -> no tx_start until tx_busy=0, then exactly one pulse; byte order unchanged.
- Back-to-back results: second res_valid raised during byte 3 of the first frame -> no res_ack until the first frame completes; second frame (result=6'h05, opcode=2 -> 0x52 0x32 0x30 0x35 0x0D 0x0A) follows with no lost or duplicated bytes.
- Mid-frame reset: reset pulsed low after the 3rd tx_start -> outputs zero immediately, no further tx_start; after release, a new result=6'h00, opcode=0 produces 0x52 0x30 0x30 0x30 0x0D 0x0A.
